// File: rtl/vis_pkg.sv
// VGA 640x480@60 timing constants and the shared types used by the bar-graph display path.
package vis_pkg;

  localparam int unsigned HPIXELS = 640;
  localparam int unsigned HFP     = 16;
  localparam int unsigned HSPULSE = 96;
  localparam int unsigned HBP     = 48;
  localparam int unsigned HTOTAL  = HPIXELS + HFP + HSPULSE + HBP;

  localparam int unsigned VPIXELS = 480;
  localparam int unsigned VFP     = 10;
  localparam int unsigned VSPULSE = 2;
  localparam int unsigned VBP     = 33;
  localparam int unsigned VTOTAL  = VPIXELS + VFP + VSPULSE + VBP;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

endpackage

// File: rtl/bar_frame_scheduler_if.sv
// Writer handshake plus bar-height memory port; slave is the scheduler's view.
interface bar_frame_scheduler_if #(
  parameter int unsigned NUM_BARS = 32,
  parameter int unsigned HEIGHT_W = 9
);
  localparam int unsigned IDX_W = $clog2(NUM_BARS);

  logic                wr_valid;
  logic                wr_ready;
  logic [IDX_W-1:0]    wr_idx;
  logic [HEIGHT_W-1:0] wr_height;
  logic                wr_frame_done;

  logic [IDX_W:0]      mem_addr;
  logic                mem_we;
  logic [HEIGHT_W-1:0] mem_wdata;
  logic [HEIGHT_W-1:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_idx, wr_height, wr_frame_done, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_valid, wr_idx, wr_height, wr_frame_done, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/bar_column_cursor.sv
// Tracks which bar and which pixel within it the current hc falls on.
module bar_column_cursor
  import vis_pkg::*;
#(
  parameter int unsigned NUM_BARS = 32,
  parameter int unsigned BAR_W    = 20,
  localparam int unsigned IDX_W   = $clog2(NUM_BARS),
  localparam int unsigned SUB_W   = $clog2(BAR_W)
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic [9:0]       hc,
  output logic [IDX_W-1:0] bar_idx,
  output logic [SUB_W-1:0] sub
);

  logic [IDX_W-1:0] bar_idx_q, bar_idx_d;
  logic [SUB_W-1:0] sub_q, sub_d;

  // Restarting on the last column of the line keeps the cursor in step with hc=0.
  always_comb begin
    bar_idx_d = bar_idx_q;
    sub_d     = sub_q;
    if (hc == 10'(HTOTAL - 1)) begin
      bar_idx_d = '0;
      sub_d     = '0;
    end else if (sub_q == SUB_W'(BAR_W - 1)) begin
      sub_d     = '0;
      bar_idx_d = bar_idx_q + IDX_W'(1);
    end else begin
      sub_d     = sub_q + SUB_W'(1);
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      bar_idx_q <= '0;
      sub_q     <= '0;
    end else begin
      bar_idx_q <= bar_idx_d;
      sub_q     <= sub_d;
    end
  end

  assign bar_idx = bar_idx_q;
  assign sub     = sub_q;

endmodule

// File: rtl/bar_frame_scheduler.sv
// Double-banked bar-height memory arbiter: swaps/fetches once per frame in vblank
// and renders the bar graph colour from the cached front bank.
module bar_frame_scheduler
  import vis_pkg::*;
#(
  parameter int unsigned NUM_BARS = 32,
  parameter int unsigned BAR_W    = 20,
  parameter int unsigned HEIGHT_W = 9,
  parameter logic [7:0]  BAR_RGB  = 8'b000_111_11
) (
  input  logic                  vgaclk,
  input  logic                  rst,
  input  logic [9:0]            hc,
  input  logic [9:0]            vc,
  bar_frame_scheduler_if.slave  bus,
  output logic                  frame_swapped,
  output logic                  front_bank,
  output logic [2:0]            pix_red,
  output logic [2:0]            pix_green,
  output logic [1:0]            pix_blue
);

  localparam int unsigned IDX_W = $clog2(NUM_BARS);
  localparam int unsigned SUB_W = $clog2(BAR_W);

  sched_state_t        state_q, state_d;
  logic                front_bank_q, front_bank_d;
  logic                swap_pending_q, swap_pending_d;
  logic [IDX_W-1:0]    fetch_idx_q, fetch_idx_d;
  logic                cap_valid_q, cap_valid_d;
  logic [IDX_W-1:0]    cap_idx_q, cap_idx_d;
  logic [HEIGHT_W-1:0] cache_q [NUM_BARS];
  logic [HEIGHT_W-1:0] cache_d [NUM_BARS];

  logic             trig;
  logic             take_t;
  logic             swap_req;
  logic             accept;
  logic [IDX_W-1:0] bar_idx;
  logic [SUB_W-1:0] sub;

  assign trig     = (hc == 10'd0) && (vc == 10'(VPIXELS));
  assign take_t   = trig && (state_q == IDLE);
  assign swap_req = swap_pending_q | bus.wr_frame_done;

  bar_column_cursor #(
    .NUM_BARS (NUM_BARS),
    .BAR_W    (BAR_W)
  ) u_cursor (
    .vgaclk  (vgaclk),
    .rst     (rst),
    .hc      (hc),
    .bar_idx (bar_idx),
    .sub     (sub)
  );

  // Read k is issued in cycle T+k and captured one cycle later, so the capture
  // pointer trails the fetch pointer by one and DRAIN takes the last word.
  always_comb begin
    state_d        = state_q;
    front_bank_d   = front_bank_q;
    swap_pending_d = swap_pending_q | bus.wr_frame_done;
    fetch_idx_d    = fetch_idx_q;
    cap_valid_d    = 1'b0;
    cap_idx_d      = cap_idx_q;
    cache_d        = cache_q;
    if (cap_valid_q) begin
      cache_d[cap_idx_q] = bus.mem_rdata;
    end
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = FETCH;
          if (swap_req) begin
            front_bank_d   = ~front_bank_q;
            swap_pending_d = 1'b0;
          end
          fetch_idx_d = IDX_W'(1);
          cap_valid_d = 1'b1;
          cap_idx_d   = '0;
        end
      end
      FETCH: begin
        cap_valid_d = 1'b1;
        cap_idx_d   = fetch_idx_q;
        fetch_idx_d = fetch_idx_q + IDX_W'(1);
        if (fetch_idx_q == IDX_W'(NUM_BARS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      state_q        <= IDLE;
      front_bank_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      fetch_idx_q    <= '0;
      cap_valid_q    <= 1'b0;
      cap_idx_q      <= '0;
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
        cache_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      front_bank_q   <= front_bank_d;
      swap_pending_q <= swap_pending_d;
      fetch_idx_q    <= fetch_idx_d;
      cap_valid_q    <= cap_valid_d;
      cap_idx_q      <= cap_idx_d;
      cache_q        <= cache_d;
    end
  end

  assign bus.wr_ready = !rst && (state_q == IDLE) && !trig;
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign frame_swapped = !rst && take_t && swap_req;
  assign front_bank    = front_bank_q;

  // The first read at T already targets the bank being swapped in.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (!rst) begin
      if (state_q == FETCH) begin
        bus.mem_addr = {front_bank_q, fetch_idx_q};
      end else if (take_t) begin
        bus.mem_addr = {front_bank_q ^ swap_req, {IDX_W{1'b0}}};
      end else if (accept) begin
        bus.mem_addr  = {~front_bank_q, bus.wr_idx};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.wr_height;
      end
    end
  end

  logic [31:0] col_h;
  logic [31:0] col_sat;
  logic        lit;
  rgb332_t     pix;

  always_comb begin
    col_h   = 32'(cache_q[bar_idx]);
    col_sat = (col_h >= VPIXELS) ? VPIXELS : col_h;
    lit     = !rst
              && (hc < 10'(HPIXELS))
              && (vc < 10'(VPIXELS))
              && (sub != SUB_W'(BAR_W - 1))
              && (32'(vc) >= (VPIXELS - col_sat));
    pix     = lit ? rgb332_t'(BAR_RGB) : '0;
  end

  assign pix_red   = pix.r;
  assign pix_green = pix.g;
  assign pix_blue  = pix.b;

endmodule

// File: tb/tb_bar_frame_scheduler.sv
// Scoreboard bench for bar_frame_scheduler: expected outputs queued per cycle, popped at negedge.
module tb_bar_frame_scheduler;

  localparam int unsigned NB = 32;
  localparam int unsigned BW = 20;
  localparam int unsigned HW = 9;
  localparam logic [7:0]  RGB = 8'b000_111_11;

  localparam int S_PIX = 0, S_RDY = 1, S_WE = 2, S_ADDR = 3, S_WDATA = 4, S_SWAP = 5, S_FRONT = 6;

  logic       vgaclk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hc = '0;
  logic [9:0] vc = '0;
  logic       frame_swapped, front_bank;
  logic [2:0] pix_red, pix_green;
  logic [1:0] pix_blue;

  bar_frame_scheduler_if #(.NUM_BARS(NB), .HEIGHT_W(HW)) bus ();

  bar_frame_scheduler #(
    .NUM_BARS (NB),
    .BAR_W    (BW),
    .HEIGHT_W (HW),
    .BAR_RGB  (RGB)
  ) dut (
    .vgaclk        (vgaclk),
    .rst           (rst),
    .hc            (hc),
    .vc            (vc),
    .bus           (bus),
    .frame_swapped (frame_swapped),
    .front_bank    (front_bank),
    .pix_red       (pix_red),
    .pix_green     (pix_green),
    .pix_blue      (pix_blue)
  );

  always #5 vgaclk = ~vgaclk;

  logic [HW-1:0] mem [64];
  logic [HW-1:0] rdata_q = '0;
  always @(posedge vgaclk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  logic [HW-1:0] model_mem [64];
  logic [HW-1:0] model_cache [NB];
  logic          model_front;
  logic          model_pending;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic logic [31:0] act(input int sig);
    case (sig)
      S_PIX:   return 32'({pix_red, pix_green, pix_blue});
      S_RDY:   return 32'(bus.wr_ready);
      S_WE:    return 32'(bus.mem_we);
      S_ADDR:  return 32'(bus.mem_addr);
      S_WDATA: return 32'(bus.mem_wdata);
      S_SWAP:  return 32'(frame_swapped);
      S_FRONT: return 32'(front_bank);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge vgaclk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, act(e.sig), e.val);
    end
    @(posedge vgaclk);
    #1;
  endtask

  task automatic do_write(input int idx, input int h);
    logic [5:0] a;
    hc = 10'd100; vc = 10'd100;
    bus.wr_valid = 1'b1; bus.wr_idx = 5'(idx); bus.wr_height = 9'(h);
    a = {~model_front, 5'(idx)};
    push_exp("wr_ready", S_RDY, 32'd1);
    push_exp("wr_we", S_WE, 32'd1);
    push_exp("wr_addr", S_ADDR, 32'(a));
    push_exp("wr_data", S_WDATA, 32'(h));
    model_mem[a] = 9'(h);
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  task automatic frame_done();
    hc = 10'd200; vc = 10'd200;
    bus.wr_frame_done = 1'b1;
    model_pending = 1'b1;
    push_exp("done_no_swap", S_SWAP, 32'd0);
    cyc();
    bus.wr_frame_done = 1'b0;
  endtask

  task automatic run_t(input bit done_at_t, input bit hold_write);
    bit swap;
    logic [5:0] a;
    hc = 10'd799; vc = 10'd479;
    cyc();
    if (hold_write) begin
      bus.wr_valid = 1'b1; bus.wr_idx = 5'd1; bus.wr_height = 9'd55;
    end
    for (int i = 0; i <= 33; i++) begin
      hc = 10'(i); vc = 10'd480;
      bus.wr_frame_done = (i == 0) && done_at_t;
      if (i == 0) begin
        swap = model_pending || done_at_t;
        push_exp("swap_at_t", S_SWAP, 32'(swap));
        if (swap) model_front = ~model_front;
        model_pending = 1'b0;
        for (int k = 0; k < NB; k++) model_cache[k] = model_mem[{model_front, 5'(k)}];
      end else begin
        push_exp("swap_quiet", S_SWAP, 32'd0);
        push_exp("front_bank", S_FRONT, 32'(model_front));
      end
      if (i <= 31) push_exp("fetch_addr", S_ADDR, 32'({model_front, 5'(i)}));
      if (i <= 32) begin
        push_exp("fetch_rdy", S_RDY, 32'd0);
        push_exp("fetch_we", S_WE, 32'd0);
      end else if (hold_write) begin
        a = {~model_front, 5'd1};
        push_exp("first_acc_rdy", S_RDY, 32'd1);
        push_exp("first_acc_we", S_WE, 32'd1);
        push_exp("first_acc_addr", S_ADDR, 32'(a));
        push_exp("first_acc_data", S_WDATA, 32'd55);
        model_mem[a] = 9'd55;
      end
      push_exp("vblank_pix", S_PIX, 32'd0);
      cyc();
      bus.wr_frame_done = 1'b0;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic render_line(input int vcv, input int hmax);
    int bar, sb, ht, sat;
    bit lit;
    hc = 10'd799; vc = 10'(vcv);
    push_exp("pix_blank", S_PIX, 32'd0);
    cyc();
    for (int h = 0; h < hmax; h++) begin
      hc = 10'(h);
      bar = (h / BW) % NB;
      sb  = h % BW;
      ht  = int'(model_cache[bar]);
      sat = (ht >= 480) ? 480 : ht;
      lit = (h < 640) && (vcv < 480) && (sb != BW - 1) && (vcv >= 480 - sat);
      push_exp("pix", S_PIX, lit ? 32'(RGB) : 32'd0);
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    for (int i = 0; i < NB; i++) model_cache[i] = '0;
    model_front = 1'b0;
    model_pending = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_idx = '0; bus.wr_height = '0; bus.wr_frame_done = 1'b0;

    // Reset: outputs quiet even with a write offered.
    rst = 1'b1; hc = 10'd100; vc = 10'd400; bus.wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp("rst_rdy", S_RDY, 32'd0);
      push_exp("rst_we", S_WE, 32'd0);
      push_exp("rst_addr", S_ADDR, 32'd0);
      push_exp("rst_swap", S_SWAP, 32'd0);
      push_exp("rst_front", S_FRONT, 32'd0);
      push_exp("rst_pix", S_PIX, 32'd0);
      cyc();
    end
    bus.wr_valid = 1'b0;
    rst = 1'b0;

    // Swap with writes into bank 1.
    do_write(3, 100);
    do_write(5, 511);
    do_write(9, 480);
    do_write(10, 479);
    frame_done();
    run_t(1'b0, 1'b1);

    render_line(380, 660);
    render_line(379, 640);
    render_line(0, 640);
    render_line(1, 640);

    // No swap request: fetch still runs on the same bank.
    do_write(3, 50);
    run_t(1'b0, 1'b0);
    render_line(380, 640);

    // Done twice while pending, then a write after done still hits the back bank.
    frame_done();
    frame_done();
    do_write(4, 300);
    run_t(1'b0, 1'b0);
    render_line(430, 640);

    // Done arriving exactly at T.
    run_t(1'b1, 1'b0);
    render_line(0, 640);

    // Reset in the middle of a fetch.
    hc = 10'd799; vc = 10'd479;
    cyc();
    for (int i = 0; i < 10; i++) begin
      hc = 10'(i); vc = 10'd480;
      push_exp("mf_addr", S_ADDR, 32'({model_front, 5'(i)}));
      cyc();
    end
    rst = 1'b1; hc = 10'd100; vc = 10'd100;
    bus.wr_valid = 1'b1; bus.wr_idx = 5'd2; bus.wr_height = 9'd7;
    for (int i = 0; i < 2; i++) begin
      push_exp("mf_rst_rdy", S_RDY, 32'd0);
      push_exp("mf_rst_we", S_WE, 32'd0);
      push_exp("mf_rst_addr", S_ADDR, 32'd0);
      push_exp("mf_rst_pix", S_PIX, 32'd0);
      cyc();
    end
    rst = 1'b0;
    model_front = 1'b0;
    model_pending = 1'b0;
    for (int k = 0; k < NB; k++) model_cache[k] = '0;
    push_exp("mf_front", S_FRONT, 32'd0);
    push_exp("mf_idle_rdy", S_RDY, 32'd1);
    push_exp("mf_idle_addr", S_ADDR, 32'h22);
    model_mem[6'h22] = 9'd7;
    cyc();
    bus.wr_valid = 1'b0;
    render_line(0, 640);
    render_line(479, 640);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bar_frame_scheduler.md
# bar_frame_scheduler

Arbitrates a single-port, double-banked bar-height memory between the audio analysis writer and the VGA display path, and renders the bar-graph pixel colour for the `vga` timing module. Once per frame, at the start of vertical blanking, it swaps banks if the writer has finished a frame. It then fetches all bar heights of the front bank into a local cache. It drives the 3/3/2 colour inputs of `vga` from the `hc`/`vc` counters that `vga` exports.

## Interface
- NUM_BARS, 32: bars across the screen; power of two.
- BAR_W, 20: pixels per bar; NUM_BARS*BAR_W must equal 640.
- HEIGHT_W, 9: bar-height width in pixels.
- BAR_RGB, 8'b000_111_11: {r3,g3,b2} colour of lit pixels.

- vgaclk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- hc, vc  in  10 each  counters from `vga`; 0..799 and 0..524.
- wr_valid  in  1  writer holds a height write.
- wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready.
- wr_idx  in  log2(NUM_BARS)  bar index to write.
- wr_height  in  HEIGHT_W  height value.
- wr_frame_done  in  1  one-cycle pulse: back bank complete, request swap.
- frame_swapped  out  1  one-cycle pulse when a swap is taken.
- front_bank  out  1  bank currently displayed.
- mem_addr  out  1+log2(NUM_BARS)  {bank, idx}.
- mem_we  out  1  write strobe.
- mem_wdata  out  HEIGHT_W  write data.
- mem_rdata  in  HEIGHT_W  read data, valid one cycle after the address.
- pix_red, pix_green  out  3 each; pix_blue  out  2  colour to `vga`.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- Trigger cycle T: the cycle where hc==0 && vc==480.
- swap_req = swap_pending | wr_frame_done.
- At T, if swap_req: toggle front_bank, clear swap_pending, pulse frame_swapped. Enter FETCH regardless.
- In FETCH, issue reads at mem_addr={front_bank, k} for k=0..NUM_BARS-1, one per cycle with mem_we=0. Data for k is captured into cache[k] one cycle later. After k=NUM_BARS-1, go to DRAIN for one capture cycle, then IDLE.
- wr_ready = (state==IDLE) && !T.
- On an accepted write: mem_addr={~front_bank, wr_idx}, mem_we=1, mem_wdata=wr_height. Otherwise mem_we=0.
- The writer must not write the front bank; this is enforced by construction.
- wr_frame_done while a swap is already pending: no effect, stays pending. Writes after done but before T still go to the current back bank.
- Column cursor: bar_idx and sub, both registered. When hc==799, both become 0 on the next edge. Otherwise sub increments; when sub==BAR_W-1 it wraps to 0 and bar_idx increments. This keeps bar_idx/sub aligned with the current hc.
- Pixel lit when all of the following hold:
  - hc<640 and vc<480
  - sub!=BAR_W-1 (1-pixel gap)
  - vc >= 480 - min(cache[bar_idx], 480); heights of 480 or more saturate to a full column.
- A lit pixel outputs BAR_RGB; every other pixel outputs 0.

## Timing
- Reset values: state=IDLE, front_bank=0, swap_pending=0, cache all 0, bar_idx=sub=0, frame_swapped=0, mem_we=0, mem_addr=0, wr_ready=0 during rst, pix_*=0.
- Reset mid-FETCH aborts the fetch and clears the cache; the next fetch happens at the next T.
- Pixel colour is combinational from hc/vc/cursor/cache, i.e. 0 cycles after hc.
- The fetch window spans T..T+NUM_BARS inclusive (33 cycles); wr_ready=0 throughout, and the last capture happens at T+NUM_BARS.
- The cache is updated only during vblank, so there is no tearing.
- If wr_frame_done arrives at T, the swap is taken at T.

## Structure
- Shared package vis_pkg: HPIXELS/HFP/HSPULSE/HBP, VPIXELS/VFP/VSPULSE/VBP, HTOTAL=800, VTOTAL=525, the sched_state_t enum, and a rgb332_t typedef.
- Sub-module bar_column_cursor: hc -> bar_idx/sub counters.

## Test plan
- **Swap:** after reset, write bar 3=100 into bank 1, pulse wr_frame_done, run to T -> frame_swapped at T, front_bank=1, reads at 6'h20..6'h3F, cache[3]=100.
- **Render:** with cache[3]=100 -> at vc=380 and hc=60..78, BAR_RGB is output; at hc=79 (gap), vc=379, or hc>=640, the output is 0.
- **Arbitration:** hold wr_valid through T -> wr_ready=0 from T to T+32 with no mem_we, then the first accept occurs at T+33.
- **Saturation:** height 511 -> lit at vc=0. Height 0 -> never lit.
- **No swap:** no wr_frame_done before T -> no frame_swapped, front_bank unchanged, fetch still runs.
- **Mid-fetch reset:** assert rst at T+10 -> cache all 0, state IDLE, front_bank=0, pix_* 0.
